// File: rtl/rx_payload_enq_ctrl_pkg.sv
// Shared RX payload queue definitions: default widths and the enqueue FSM states.
package rx_payload_enq_ctrl_pkg;

  localparam int RX_FLOW_ID_W        = 8;
  localparam int RX_PAYLOAD_Q_SIZE_W = 3;
  localparam int RX_PAYLOAD_ENTRY_W  = 64;
  localparam int RX_STAT_CNT_W       = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    QUERY  = 2'd1,
    RESP   = 2'd2,
    COMMIT = 2'd3
  } rx_enq_state_t;

endpackage

// File: rtl/rx_payload_enq_ctrl_datapath.sv
// Capture registers, queue-full compare, tail increment and statistics counters
// for the RX payload enqueue controller.
module rx_payload_enq_ctrl_datapath
  import rx_payload_enq_ctrl_pkg::*;
#(
  parameter int FLOW_ID_W       = RX_FLOW_ID_W,
  parameter int Q_SIZE_W        = RX_PAYLOAD_Q_SIZE_W,
  parameter int PAYLOAD_ENTRY_W = RX_PAYLOAD_ENTRY_W,
  parameter int CNT_W           = RX_STAT_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cap_pkt,
  input  logic [FLOW_ID_W-1:0]       pkt_flowid,
  input  logic [PAYLOAD_ENTRY_W-1:0] pkt_desc,
  input  logic                       cap_resp,
  input  logic [Q_SIZE_W:0]          resp_head,
  input  logic [Q_SIZE_W:0]          resp_tail,
  input  logic                       inc_enq,
  input  logic                       inc_drop,
  output logic                       resp_full,
  output logic [FLOW_ID_W-1:0]       cap_flowid,
  output logic [PAYLOAD_ENTRY_W-1:0] cap_desc,
  output logic [Q_SIZE_W:0]          cap_tail,
  output logic [Q_SIZE_W:0]          cap_tail_next,
  output logic [CNT_W-1:0]           enq_cnt,
  output logic [CNT_W-1:0]           drop_cnt
);

  typedef struct packed {
    logic [FLOW_ID_W-1:0]       flowid;
    logic [PAYLOAD_ENTRY_W-1:0] payload_desc;
  } rx_payload_desc_t;

  // Occupancy equal to exactly one full lap of the ring means full.
  localparam logic [Q_SIZE_W:0] PTR_FULL_OCC = {1'b1, {Q_SIZE_W{1'b0}}};
  localparam logic [Q_SIZE_W:0] PTR_ONE      = {{Q_SIZE_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

  // Modulo pointer distance; also handles head numerically ahead of tail.
  function automatic logic q_is_full(input logic [Q_SIZE_W:0] head,
                                     input logic [Q_SIZE_W:0] tail);
    logic [Q_SIZE_W:0] occ;
    occ = tail - head;
    return (occ == PTR_FULL_OCC);
  endfunction

  rx_payload_desc_t cap_q;

  assign resp_full  = q_is_full(resp_head, resp_tail);
  assign cap_flowid = cap_q.flowid;
  assign cap_desc   = cap_q.payload_desc;

  // Latch the descriptor when upstream hands it over.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_q <= '0;
    end else if (cap_pkt) begin
      cap_q.flowid       <= pkt_flowid;
      cap_q.payload_desc <= pkt_desc;
    end
  end

  // Latch the tail slot and precompute its wrapped successor at response time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_tail      <= '0;
      cap_tail_next <= '0;
    end else if (cap_resp) begin
      cap_tail      <= resp_tail;
      cap_tail_next <= resp_tail + PTR_ONE;
    end
  end

  // Free-running wrap-around statistics counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enq_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (inc_enq)  enq_cnt  <= enq_cnt + CNT_ONE;
      if (inc_drop) drop_cnt <= drop_cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/rx_payload_enq_ctrl.sv
// RX payload descriptor enqueue controller: queries per-flow queue pointers,
// enqueues at the tail and writes back tail+1, or drops when the queue is full.
module rx_payload_enq_ctrl
  import rx_payload_enq_ctrl_pkg::*;
#(
  parameter int FLOW_ID_W       = RX_FLOW_ID_W,
  parameter int Q_SIZE_W        = RX_PAYLOAD_Q_SIZE_W,
  parameter int PAYLOAD_ENTRY_W = RX_PAYLOAD_ENTRY_W,
  parameter int CNT_W           = RX_STAT_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pkt_val,
  input  logic [FLOW_ID_W-1:0]       pkt_flowid,
  input  logic [PAYLOAD_ENTRY_W-1:0] pkt_desc,
  output logic                       pkt_rdy,
  output logic                       q_full_req_val,
  output logic [FLOW_ID_W-1:0]       q_full_req_flowid,
  input  logic                       q_full_req_rdy,
  input  logic                       q_full_resp_val,
  input  logic [Q_SIZE_W:0]          q_full_resp_head_index,
  input  logic [Q_SIZE_W:0]          q_full_resp_tail_index,
  output logic                       q_full_resp_rdy,
  output logic                       enqueue_pkt_req_val,
  output logic [FLOW_ID_W-1:0]       enqueue_pkt_req_flowid,
  output logic [PAYLOAD_ENTRY_W-1:0] enqueue_pkt_req_data,
  output logic [Q_SIZE_W:0]          enqueue_pkt_req_index,
  input  logic                       enqueue_pkt_req_rdy,
  output logic                       new_tail_val,
  output logic [FLOW_ID_W-1:0]       new_tail_addr,
  output logic [Q_SIZE_W:0]          new_tail_data,
  input  logic                       new_tail_rdy,
  output logic [CNT_W-1:0]           enq_cnt,
  output logic [CNT_W-1:0]           drop_cnt
);

  rx_enq_state_t state;
  logic          enq_done;
  logic          tail_done;

  logic                 pkt_fire;
  logic                 resp_fire;
  logic                 enq_fire;
  logic                 tail_fire;
  logic                 commit_done;
  logic                 drop_now;
  logic                 resp_full;
  logic [FLOW_ID_W-1:0] cap_flowid;

  assign pkt_fire    = pkt_val & pkt_rdy;
  assign resp_fire   = q_full_resp_val & q_full_resp_rdy;
  assign enq_fire    = enqueue_pkt_req_val & enqueue_pkt_req_rdy;
  assign tail_fire   = new_tail_val & new_tail_rdy;
  assign drop_now    = resp_fire & resp_full;
  // Each channel completes on its own; the descriptor retires once both have.
  assign commit_done = (state == COMMIT) & (enq_done | enq_fire) & (tail_done | tail_fire);

  assign q_full_req_flowid      = cap_flowid;
  assign enqueue_pkt_req_flowid = cap_flowid;
  assign new_tail_addr          = cap_flowid;

  rx_payload_enq_ctrl_datapath #(
    .FLOW_ID_W       (FLOW_ID_W),
    .Q_SIZE_W        (Q_SIZE_W),
    .PAYLOAD_ENTRY_W (PAYLOAD_ENTRY_W),
    .CNT_W           (CNT_W)
  ) u_datapath (
    .clk           (clk),
    .rst           (rst),
    .cap_pkt       (pkt_fire),
    .pkt_flowid    (pkt_flowid),
    .pkt_desc      (pkt_desc),
    .cap_resp      (resp_fire),
    .resp_head     (q_full_resp_head_index),
    .resp_tail     (q_full_resp_tail_index),
    .inc_enq       (commit_done),
    .inc_drop      (drop_now),
    .resp_full     (resp_full),
    .cap_flowid    (cap_flowid),
    .cap_desc      (enqueue_pkt_req_data),
    .cap_tail      (enqueue_pkt_req_index),
    .cap_tail_next (new_tail_data),
    .enq_cnt       (enq_cnt),
    .drop_cnt      (drop_cnt)
  );

  // One-descriptor-in-flight FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= IDLE;
      pkt_rdy             <= 1'b0;
      q_full_req_val      <= 1'b0;
      q_full_resp_rdy     <= 1'b0;
      enqueue_pkt_req_val <= 1'b0;
      new_tail_val        <= 1'b0;
      enq_done            <= 1'b0;
      tail_done           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pkt_fire) begin
            state          <= QUERY;
            pkt_rdy        <= 1'b0;
            q_full_req_val <= 1'b1;
          end else begin
            pkt_rdy <= 1'b1;
          end
        end
        QUERY: begin
          if (q_full_req_rdy) begin
            state           <= RESP;
            q_full_req_val  <= 1'b0;
            q_full_resp_rdy <= 1'b1;
          end
        end
        RESP: begin
          if (q_full_resp_val) begin
            q_full_resp_rdy <= 1'b0;
            if (resp_full) begin
              state   <= IDLE;
              pkt_rdy <= 1'b1;
            end else begin
              state               <= COMMIT;
              enqueue_pkt_req_val <= 1'b1;
              new_tail_val        <= 1'b1;
              enq_done            <= 1'b0;
              tail_done           <= 1'b0;
            end
          end
        end
        COMMIT: begin
          if (enq_fire) begin
            enqueue_pkt_req_val <= 1'b0;
            enq_done            <= 1'b1;
          end
          if (tail_fire) begin
            new_tail_val <= 1'b0;
            tail_done    <= 1'b1;
          end
          if (commit_done) begin
            state   <= IDLE;
            pkt_rdy <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/rx_payload_enq_ctrl.md
Name: rx_payload_enq_ctrl

Overview:
Upstream feeder for the per-flow RX payload descriptor queue. It accepts one received-packet payload descriptor at a time and queries that queue's head/tail pointers for the flow. If the queue has room, it issues an enqueue at the tail index and then writes back the incremented tail. If the queue is full, it drops the descriptor and counts the drop. It sits between the RX packet parse/payload-buffer allocator and the payload queue.

Parameters:
FLOW_ID_W, 8, flow identifier width
Q_SIZE_W, 3, log2 of per-flow queue depth; pointers are Q_SIZE_W+1 bits (extra wrap bit)
PAYLOAD_ENTRY_W, 64, payload descriptor width
CNT_W, 32, statistics counter width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
pkt_val  in  1  descriptor valid from upstream
pkt_flowid  in  FLOW_ID_W  flow of descriptor
pkt_desc  in  PAYLOAD_ENTRY_W  payload descriptor
pkt_rdy  out  1  block can accept a descriptor
q_full_req_val  out  1  pointer query valid
q_full_req_flowid  out  FLOW_ID_W  flow being queried
q_full_req_rdy  in  1  queue accepts query
q_full_resp_val  in  1  pointer response valid
q_full_resp_head_index  in  Q_SIZE_W+1  current head pointer
q_full_resp_tail_index  in  Q_SIZE_W+1  current tail pointer
q_full_resp_rdy  out  1  block accepts response
enqueue_pkt_req_val  out  1  enqueue request valid
enqueue_pkt_req_flowid  out  FLOW_ID_W  enqueue flow
enqueue_pkt_req_data  out  PAYLOAD_ENTRY_W  descriptor to store
enqueue_pkt_req_index  out  Q_SIZE_W+1  slot index (= captured tail)
enqueue_pkt_req_rdy  in  1  queue accepts enqueue
new_tail_val  out  1  tail pointer write valid
new_tail_addr  out  FLOW_ID_W  flow whose tail is written
new_tail_data  out  Q_SIZE_W+1  tail+1
new_tail_rdy  in  1  pointer memory accepts write
enq_cnt  out  CNT_W  descriptors successfully enqueued
drop_cnt  out  CNT_W  descriptors dropped due to full queue

Behaviour:
- Reset (rst low, async): state=IDLE; all *_val outputs 0; pkt_rdy=0 during reset and 1 after reset in IDLE; q_full_resp_rdy=0; enq_cnt=drop_cnt=0; captured registers cleared.
- Reset asserted mid-operation discards the in-flight descriptor with no partial tail write. An enqueue already accepted is left as-is.
- All handshakes are val&rdy in the same cycle. Outputs hold stable while val=1 and rdy=0.
- FSM states:
  - IDLE: pkt_rdy=1. On pkt_val, capture flowid/desc and go to QUERY.
  - QUERY: q_full_req_val=1 with the captured flowid. On q_full_req_rdy, go to RESP.
  - RESP: q_full_resp_rdy=1. On q_full_resp_val, capture head/tail.
    - Full = ((tail - head) mod 2^(Q_SIZE_W+1)) == 2^Q_SIZE_W.
    - If full: drop_cnt++ and go to IDLE.
    - Otherwise go to COMMIT.
  - COMMIT: enqueue_pkt_req_val and new_tail_val asserted together.
    - new_tail_data = (tail+1) mod 2^(Q_SIZE_W+1); the wrap bit toggles when the index wraps.
    - The two handshakes complete independently. A per-channel done flag deasserts that channel's val after acceptance.
    - When both are done: enq_cnt++ and go to IDLE.
- Ordering: one descriptor in flight, so same-flow back-to-back descriptors see the updated tail. The queue's pointer memory must expose a write on the next query (at least one cycle later).
- Latency: with all rdys high and the response arriving the cycle after the query, accept at cycle 0, query at 1, response at 2, commit at 3, pkt_rdy at 4. Peak throughput is 1 descriptor per 4 cycles.
- Counters wrap at 2^CNT_W.
- A response arriving in any state other than RESP is ignored (q_full_resp_rdy=0).
- Empty queue (head==tail) is never full. Head ahead of tail is treated by the same modulo arithmetic.

Decomposition:
- Shared package (existing RX payload queue defs): flow id width, RX_PAYLOAD_Q_SIZE_W, PAYLOAD_ENTRY_W, and the state enum {IDLE, QUERY, RESP, COMMIT}.
- Packed struct for the captured descriptor {flowid, payload_desc}.
- A separate control/datapath split is natural: rx_payload_enq_ctrl_datapath holds the capture registers, full compare, tail increment and counters. The top holds the FSM.

Test Plan:
- Empty queue: flow 5, head=0 tail=0, desc 0xA5 -> enqueue index 0 data 0xA5 flow 5; new_tail_data=1; enq_cnt=1; pkt_rdy back 4 cycles after accept.
- Full: head=0b0010 tail=0b1010 (depth 8) -> no enqueue/tail write; drop_cnt=1; return to IDLE the cycle after the response.
- Wrap: head=0b0011 tail=0b0111 -> index 7, new_tail_data=0b1000. Then tail=0b1111, head=0b1001 -> new_tail_data=0b0000.
- Backpressure: enqueue_pkt_req_rdy low 3 cycles, new_tail_rdy high -> new_tail_val pulses once; enqueue val/data stable for 3 cycles, then accepted; single enq_cnt increment.
- Stalled query/response: q_full_req_rdy low 2 cycles, response delayed 5 cycles -> outputs held; pkt_rdy stays 0 throughout.
- Async reset asserted in COMMIT -> all vals drop immediately, counters 0, no tail write. After deassert, a new descriptor is processed normally.
